selecteur_de_multi: RTL and testbench



---
 rtl/selecteur_de_multi_if.sv | 24 ++
 rtl/selecteur_de_multi.sv | 156 +++++++++++++++
 tb/tb_selecteur_de_multi.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/selecteur_de_multi_if.sv
// Raw push-button inputs and registered selection outputs of the dice selector.
interface selecteur_de_multi_if;
  logic       suivant;
  logic       precedent;
  logic       plus_des;
  logic       moins_des;
  logic [2:0] id_de;
  logic [6:0] min_de;
  logic [6:0] faces_de;
  logic [3:0] nb_des;
  logic [9:0] somme_min;
  logic [9:0] somme_max;
  logic       maj;

  modport master (
    output suivant, precedent, plus_des, moins_des,
    input  id_de, min_de, faces_de, nb_des, somme_min, somme_max, maj
  );

  modport slave (
    input  suivant, precedent, plus_des, moins_des,
    output id_de, min_de, faces_de, nb_des, somme_min, somme_max, maj
  );
endinterface

// File: rtl/selecteur_de_multi.sv
// Debounced dice-type / dice-count selector: four buttons step the die type and
// count, and the per-die bounds and total roll range are published as registers.
module selecteur_de_multi #(
  parameter int NB_TYPES   = 8,
  parameter int NB_DES_MAX = 9,
  parameter int ID_INIT    = 2,
  parameter int ANTIREBOND = 16,
  parameter int BOUCLE     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  selecteur_de_multi_if.slave  bus
);

  localparam int         CW      = (ANTIREBOND < 2) ? 1 : $clog2(ANTIREBOND);
  localparam logic [2:0] ID_MAX  = 3'(NB_TYPES - 1);
  localparam logic [2:0] ID_RST  = 3'(ID_INIT);
  localparam logic [3:0] NB_MAX  = 4'(NB_DES_MAX);

  localparam int B_SUIV  = 0;
  localparam int B_PREC  = 1;
  localparam int B_PLUS  = 2;
  localparam int B_MOINS = 3;

  function automatic logic [6:0] f_faces(input logic [2:0] id);
    case (id)
      3'd0:    return 7'd2;
      3'd1:    return 7'd4;
      3'd2:    return 7'd6;
      3'd3:    return 7'd8;
      3'd4:    return 7'd10;
      3'd5:    return 7'd12;
      3'd6:    return 7'd20;
      default: return 7'd100;
    endcase
  endfunction

  // d10 and d100 are numbered from zero.
  function automatic logic [6:0] f_min(input logic [2:0] id);
    case (id)
      3'd4, 3'd7: return 7'd0;
      default:    return 7'd1;
    endcase
  endfunction

  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_acc;
  logic [3:0]    r_acc_d;
  logic [3:0]    r_press;
  logic [CW-1:0] r_cnt [4];

  assign w_raw = {bus.moins_des, bus.plus_des, bus.precedent, bus.suivant};

  // Synchroniser, debounce and rising-edge detection for all four buttons.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      r_press <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // safe and desirable to clear it with the asynchronous reset.
      for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_acc_d <= r_acc;
      r_press <= r_acc & ~r_acc_d;
      for (int b = 0; b < 4; b++) begin
        if (r_sync2[b] == r_acc[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CW'(ANTIREBOND - 1)) begin
          r_acc[b] <= r_sync2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  logic [2:0] r_id;
  logic [3:0] r_nb;
  logic [6:0] r_min;
  logic [6:0] r_faces;
  logic [9:0] r_smin;
  logic [9:0] r_smax;
  logic       r_maj;

  logic [2:0] w_id_nxt;
  logic [3:0] w_nb_nxt;
  logic [6:0] w_min_nxt;
  logic [6:0] w_faces_nxt;
  logic [6:0] w_top_nxt;
  logic [9:0] w_smin_nxt;
  logic [9:0] w_smax_nxt;

  // NOTE: defaults first, so every path assigns both outputs and no latch forms.
  always_comb begin
    w_id_nxt = r_id;
    w_nb_nxt = r_nb;
    if (r_press[B_SUIV] && !r_press[B_PREC]) begin
      if (r_id == ID_MAX) w_id_nxt = (BOUCLE != 0) ? 3'd0 : r_id;
      else                w_id_nxt = r_id + 3'd1;
    end else if (r_press[B_PREC] && !r_press[B_SUIV]) begin
      if (r_id == 3'd0) w_id_nxt = (BOUCLE != 0) ? ID_MAX : r_id;
      else              w_id_nxt = r_id - 3'd1;
    end
    if (r_press[B_PLUS] && !r_press[B_MOINS]) begin
      if (r_nb < NB_MAX) w_nb_nxt = r_nb + 4'd1;
    end else if (r_press[B_MOINS] && !r_press[B_PLUS]) begin
      if (r_nb > 4'd1) w_nb_nxt = r_nb - 4'd1;
    end
  end

  assign w_min_nxt   = f_min(w_id_nxt);
  assign w_faces_nxt = f_faces(w_id_nxt);
  assign w_top_nxt   = w_min_nxt + w_faces_nxt - 7'd1;
  assign w_smin_nxt  = {6'd0, w_nb_nxt} * {3'd0, w_min_nxt};
  assign w_smax_nxt  = {6'd0, w_nb_nxt} * {3'd0, w_top_nxt};

  // Bounds are computed from the next selection so they move with id/count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id    <= ID_RST;
      r_nb    <= 4'd1;
      r_min   <= f_min(ID_RST);
      r_faces <= f_faces(ID_RST);
      r_smin  <= 10'(f_min(ID_RST));
      r_smax  <= 10'(f_min(ID_RST) + f_faces(ID_RST) - 7'd1);
      r_maj   <= 1'b0;
    end else begin
      r_id    <= w_id_nxt;
      r_nb    <= w_nb_nxt;
      r_min   <= w_min_nxt;
      r_faces <= w_faces_nxt;
      r_smin  <= w_smin_nxt;
      r_smax  <= w_smax_nxt;
      r_maj   <= (w_id_nxt != r_id) || (w_nb_nxt != r_nb);
    end
  end

  assign bus.id_de     = r_id;
  assign bus.nb_des    = r_nb;
  assign bus.min_de    = r_min;
  assign bus.faces_de  = r_faces;
  assign bus.somme_min = r_smin;
  assign bus.somme_max = r_smax;
  assign bus.maj       = r_maj;

endmodule

// File: tb/tb_selecteur_de_multi.sv
// Bench for selecteur_de_multi: a wrapping and a saturating instance share the
// buttons; a scheduled-press model predicts outputs, checked every cycle.
module tb_selecteur_de_multi;
  localparam int NT   = 8;
  localparam int NMAX = 9;
  localparam int IDI  = 2;
  localparam int A    = 16;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] r_btn   = '0;

  always #5 clk = ~clk;

  selecteur_de_multi_if bus_w ();
  selecteur_de_multi_if bus_s ();

  assign bus_w.suivant   = r_btn[0];
  assign bus_w.precedent = r_btn[1];
  assign bus_w.plus_des  = r_btn[2];
  assign bus_w.moins_des = r_btn[3];
  assign bus_s.suivant   = r_btn[0];
  assign bus_s.precedent = r_btn[1];
  assign bus_s.plus_des  = r_btn[2];
  assign bus_s.moins_des = r_btn[3];

  selecteur_de_multi #(.NB_TYPES(NT), .NB_DES_MAX(NMAX), .ID_INIT(IDI),
                       .ANTIREBOND(A), .BOUCLE(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(bus_w));

  selecteur_de_multi #(.NB_TYPES(NT), .NB_DES_MAX(NMAX), .ID_INIT(IDI),
                       .ANTIREBOND(A), .BOUCLE(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;
  int m_id  [2];
  int m_nb  [2];
  int m_maj [2];
  logic [3:0] sched [int];

  int FACES [8] = '{2, 4, 6, 8, 10, 12, 20, 100};
  int MINS  [8] = '{1, 1, 1, 1, 0, 1, 1, 0};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sched_add(input int t, input logic [3:0] m);
    if (sched.exists(t)) sched[t] = sched[t] | m;
    else                 sched[t] = m;
  endtask

  // Model: a press accepted at edge t changes the selection at edge t+A+3.
  // Instance 0 wraps the type id, instance 1 saturates it.
  always @(posedge clk or negedge reset_n) begin
    int ev, nid, nnb;
    if (!reset_n) begin
      cyc = 0;
      sched.delete();
      for (int k = 0; k < 2; k++) begin
        m_id[k] = IDI; m_nb[k] = 1; m_maj[k] = 0;
      end
    end else begin
      cyc++;
      ev = sched.exists(cyc) ? int'(sched[cyc]) : 0;
      for (int k = 0; k < 2; k++) begin
        nid = m_id[k];
        nnb = m_nb[k];
        if (ev[0] && !ev[1])
          nid = (m_id[k] == NT - 1) ? ((k == 0) ? 0 : m_id[k]) : m_id[k] + 1;
        else if (ev[1] && !ev[0])
          nid = (m_id[k] == 0) ? ((k == 0) ? NT - 1 : 0) : m_id[k] - 1;
        if (ev[2] && !ev[3])      nnb = (m_nb[k] + 1 > NMAX) ? NMAX : m_nb[k] + 1;
        else if (ev[3] && !ev[2]) nnb = (m_nb[k] - 1 < 1) ? 1 : m_nb[k] - 1;
        m_maj[k] = (nid != m_id[k] || nnb != m_nb[k]) ? 1 : 0;
        m_id[k]  = nid;
        m_nb[k]  = nnb;
      end
    end
  end

  task automatic cmp_inst(input int k, input string tag, input int id, input int nb,
                          input int mn, input int fc, input int smin, input int smax,
                          input int mj);
    check({tag, "_id"},    id,   m_id[k]);
    check({tag, "_nb"},    nb,   m_nb[k]);
    check({tag, "_min"},   mn,   MINS[m_id[k]]);
    check({tag, "_faces"}, fc,   FACES[m_id[k]]);
    check({tag, "_smin"},  smin, m_nb[k] * MINS[m_id[k]]);
    check({tag, "_smax"},  smax, m_nb[k] * (MINS[m_id[k]] + FACES[m_id[k]] - 1));
    check({tag, "_maj"},   mj,   m_maj[k]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, "wrap", int'(bus_w.id_de), int'(bus_w.nb_des), int'(bus_w.min_de),
               int'(bus_w.faces_de), int'(bus_w.somme_min), int'(bus_w.somme_max),
               int'(bus_w.maj));
      cmp_inst(1, "sat", int'(bus_s.id_de), int'(bus_s.nb_des), int'(bus_s.min_de),
               int'(bus_s.faces_de), int'(bus_s.somme_min), int'(bus_s.somme_max),
               int'(bus_s.maj));
    end
  end

  // Literal expectations on the wrapping instance.
  task automatic lit_w(input string tag, input int id, input int nb, input int smin,
                       input int smax, input int mj);
    check({tag, "_id"},   int'(bus_w.id_de),     id);
    check({tag, "_nb"},   int'(bus_w.nb_des),    nb);
    check({tag, "_smin"}, int'(bus_w.somme_min), smin);
    check({tag, "_smax"}, int'(bus_w.somme_max), smax);
    check({tag, "_maj"},  int'(bus_w.maj),       mj);
  endtask

  task automatic press(input logic [3:0] m, input int len);
    int t;
    repeat (A + 2) @(negedge clk);
    #1;
    r_btn = r_btn | m;
    t = cyc + 1;
    if (len >= A) sched_add(t + A + 3, m);
    repeat (len) begin @(negedge clk); #1; end
    r_btn = r_btn & ~m;
    while (cyc < t + A + 3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0;
    r_btn   = '0;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drive_rand(input int b, input int n);
    int len, t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(2 * A + 6, A + 2)) @(negedge clk);
      #1;
      r_btn[b] = 1'b1;
      t = cyc + 1;
      len = ($urandom_range(2, 0) == 0) ? int'($urandom_range(A - 1, 1))
                                        : int'($urandom_range(2 * A, A));
      if (len >= A) sched_add(t + A + 3, 4'(1 << b));
      repeat (len) begin @(negedge clk); #1; end
      r_btn[b] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    bit seen;
    int at;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    lit_w("reset", 2, 1, 1, 6, 0);
    check("reset_min",   int'(bus_w.min_de),   1);
    check("reset_faces", int'(bus_w.faces_de), 6);
    check("model_reset_id", m_id[0], 2);

    // Suivant held high through reset release.
    @(negedge clk); #1;
    r_btn[0] = 1'b1;
    reset_n  = 1'b1;
    sched_add(A + 4, 4'b0001);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 4 * A && !seen; i++) begin
      @(negedge clk);
      if (bus_w.maj) begin seen = 1'b1; at = cyc; end
    end
    check("latency_edge", at, A + 4);
    check("held_id",    int'(bus_w.id_de),    3);
    check("held_faces", int'(bus_w.faces_de), 8);
    check("held_sat_id", int'(bus_s.id_de),   3);
    check("model_held_id", m_id[0], 3);
    #1;
    r_btn[0] = 1'b0;

    // Wrap versus saturate at the top.
    repeat (5) press(4'b0001, A);
    check("wrap_id",    int'(bus_w.id_de),    0);
    check("wrap_faces", int'(bus_w.faces_de), 2);
    check("wrap_min",   int'(bus_w.min_de),   1);
    check("wrap_maj",   int'(bus_w.maj),      1);
    check("sat_top_id", int'(bus_s.id_de),    7);
    check("sat_top_maj", int'(bus_s.maj),     0);
    press(4'b0010, A);
    check("wrap_back_id", int'(bus_w.id_de), 7);
    check("sat_back_id",  int'(bus_s.id_de), 6);

    // Wrap versus saturate at the bottom.
    do_reset();
    repeat (3) press(4'b0010, A);
    check("wrap_low_id",  int'(bus_w.id_de), 7);
    check("wrap_low_maj", int'(bus_w.maj),   1);
    check("sat_low_id",   int'(bus_s.id_de), 0);
    check("sat_low_maj",  int'(bus_s.maj),   0);

    // Count and sums on d100.
    repeat (8) press(4'b0100, A);
    lit_w("nb_max", 7, 9, 0, 891, 1);
    press(4'b0100, A);
    lit_w("nb_sat", 7, 9, 0, 891, 0);
    repeat (8) press(4'b1000, A);
    lit_w("nb_min", 7, 1, 0, 99, 1);
    press(4'b1000, A);
    lit_w("nb_floor", 7, 1, 0, 99, 0);

    // Debounce threshold.
    press(4'b0001, A - 1);
    lit_w("glitch", 7, 1, 0, 99, 0);
    press(4'b0001, A);
    lit_w("min_pulse", 0, 1, 1, 2, 1);

    // Simultaneous events.
    press(4'b0011, A);
    lit_w("cancel", 0, 1, 1, 2, 0);
    do_reset();
    press(4'b0101, A);
    lit_w("combo", 3, 2, 2, 16, 1);

    // Reset in the middle of a debounce.
    repeat (A + 2) @(negedge clk);
    #1;
    r_btn[0] = 1'b1;
    repeat (A / 2 + 2) @(negedge clk);
    #1;
    reset_n  = 1'b0;
    r_btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2 * A + 6) @(negedge clk);
    lit_w("mid_reset", 2, 1, 1, 6, 0);
    check("mid_reset_faces", int'(bus_w.faces_de), 6);

    // Independent random activity on all four buttons.
    fork
      drive_rand(0, 20);
      drive_rand(1, 20);
      drive_rand(2, 20);
      drive_rand(3, 20);
    join
    repeat (3 * A + 10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
